// File: rtl/fp_add_pkg.sv
// Shared definitions for the floating-point adder datapath: default operand
// widths and the normalizer state encoding.
package fp_add_pkg;

    localparam int MANT_W_DEF = 8;
    localparam int EXP_W_DEF  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

endpackage

// File: rtl/fp_normalize_shifter.sv
// Sequential left-normalizer: one shift per cycle, result k+1 edges after accept.
// Accepts only in IDLE; holds the result in DONE until out_ready is sampled high.
module fp_normalize_shifter
    import fp_add_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MANT_W-1:0]         mant_in,
    input  logic [EXP_W-1:0]          exp_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MANT_W-1:0]         mant_out,
    output logic [EXP_W-1:0]          exp_out,
    output logic [$clog2(MANT_W):0]   shiftamnt,
    output logic                      zero,
    output logic                      denorm
);

    localparam int SH_W = $clog2(MANT_W) + 1;

    norm_state_t       state, state_nxt;
    logic [MANT_W-1:0] mant_r, mant_nxt;
    logic [EXP_W-1:0]  exp_r,  exp_nxt;
    logic [SH_W-1:0]   cnt_r,  cnt_nxt;
    logic              zero_r, zero_nxt;
    logic              den_r,  den_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Working registers double as the output registers; they only move in
    // IDLE (load) and SHIFT, so DONE holds them stable under backpressure.
    always_comb begin
        state_nxt = state;
        mant_nxt  = mant_r;
        exp_nxt   = exp_r;
        cnt_nxt   = cnt_r;
        zero_nxt  = zero_r;
        den_nxt   = den_r;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    mant_nxt  = mant_in;
                    exp_nxt   = exp_in;
                    cnt_nxt   = '0;
                    zero_nxt  = 1'b0;
                    den_nxt   = 1'b0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (mant_r == '0) begin
                    zero_nxt  = 1'b1;
                    exp_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else if (mant_r[MANT_W-1]) begin
                    state_nxt = DONE;
                end else if (exp_r == '0) begin
                    den_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    mant_nxt = {mant_r[MANT_W-2:0], 1'b0};
                    exp_nxt  = exp_r - EXP_W'(1);
                    cnt_nxt  = cnt_r + SH_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_r <= '0;
            exp_r  <= '0;
            cnt_r  <= '0;
            zero_r <= 1'b0;
            den_r  <= 1'b0;
        end else begin
            mant_r <= mant_nxt;
            exp_r  <= exp_nxt;
            cnt_r  <= cnt_nxt;
            zero_r <= zero_nxt;
            den_r  <= den_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign mant_out  = mant_r;
    assign exp_out   = exp_r;
    assign shiftamnt = cnt_r;
    assign zero      = zero_r;
    assign denorm    = den_r;

endmodule

// File: tb/tb_fp_normalize_shifter.sv
// Bench for fp_normalize_shifter: directed vector table, backpressure and
// reset sequences, then randomized operands against a leading-zero model.
module tb_fp_normalize_shifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mant_in;
    logic [4:0] exp_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] mant_out;
    logic [4:0] exp_out;
    logic [3:0] shiftamnt;
    logic       zero;
    logic       denorm;

    int n_chk  = 0;
    int n_pass = 0;

    fp_normalize_shifter #(.MANT_W(8), .EXP_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_in   (mant_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mant_out  (mant_out),
        .exp_out   (exp_out),
        .shiftamnt (shiftamnt),
        .zero      (zero),
        .denorm    (denorm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mant;
        logic [4:0] expn;
        logic [7:0] e_mant;
        logic [4:0] e_exp;
        logic [3:0] e_sh;
        logic       e_zero;
        logic       e_den;
        int         e_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Normalization from the leading-zero count: shift by lz, limited by
    // how far the exponent can fall.
    task automatic ref_model(input logic [7:0] m, input logic [4:0] e,
                             output vec_t r);
        int msb = -1;
        int lz, k, ei;
        for (int i = 0; i < 8; i++) if (m[i]) msb = i;
        ei = int'(e);
        r.mant = m;
        r.expn = e;
        if (msb < 0) begin
            r.e_mant = 8'd0; r.e_exp = 5'd0; r.e_sh = 4'd0;
            r.e_zero = 1'b1; r.e_den = 1'b0; r.e_lat = 1;
        end else begin
            lz = 7 - msb;
            k  = (lz < ei) ? lz : ei;
            r.e_mant = m << k;
            r.e_exp  = 5'(ei - k);
            r.e_sh   = 4'(k);
            r.e_zero = 1'b0;
            r.e_den  = (lz > ei);
            r.e_lat  = k + 1;
        end
    endtask

    // Presents an operand from idle, counts edges until out_valid (bounded).
    task automatic issue(input logic [7:0] m, input logic [4:0] e, output int lat);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; mant_in = m; exp_in = e;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 64) begin
            @(posedge clk); lat++; #1;
            if (out_valid) break;
        end
        chk("out_valid_rise", 32'(out_valid), 32'd1);
    endtask

    task automatic check_result(input vec_t v, input int lat, input string tag);
        chk({tag, "_mant"},   32'(mant_out),  32'(v.e_mant));
        chk({tag, "_exp"},    32'(exp_out),   32'(v.e_exp));
        chk({tag, "_shift"},  32'(shiftamnt), 32'(v.e_sh));
        chk({tag, "_zero"},   32'(zero),      32'(v.e_zero));
        chk({tag, "_denorm"}, 32'(denorm),    32'(v.e_den));
        chk({tag, "_lat"},    32'(lat),       32'(v.e_lat));
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handoff_out_valid", 32'(out_valid), 32'd0);
        chk("handoff_in_ready",  32'(in_ready),  32'd1);
    endtask

    vec_t vecs[8];
    vec_t rv;
    int   lat;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mant_in = 8'd0; exp_in = 5'd0;
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs",   32'({mant_out, exp_out, shiftamnt, zero, denorm}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs[0] = '{8'h16, 5'd10, 8'hB0, 5'd7,  4'd3, 1'b0, 1'b0, 4};
        vecs[1] = '{8'd128, 5'd5, 8'd128, 5'd5, 4'd0, 1'b0, 1'b0, 1};
        vecs[2] = '{8'd0,   5'd9, 8'd0,   5'd0, 4'd0, 1'b1, 1'b0, 1};
        vecs[3] = '{8'd1,   5'd3, 8'h08,  5'd0, 4'd3, 1'b0, 1'b1, 4};
        vecs[4] = '{8'd1,   5'd20, 8'h80, 5'd13, 4'd7, 1'b0, 1'b0, 8};
        vecs[5] = '{8'd0,   5'd0, 8'd0,   5'd0, 4'd0, 1'b1, 1'b0, 1};
        vecs[6] = '{8'h40,  5'd0, 8'h40,  5'd0, 4'd0, 1'b0, 1'b1, 1};
        vecs[7] = '{8'h40,  5'd1, 8'h80,  5'd0, 4'd1, 1'b0, 1'b0, 2};
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].mant, vecs[i].expn, lat);
            check_result(vecs[i], lat, $sformatf("vec%0d", i));
            handoff();
        end

        // Backpressure: result held, a second operand waits for the handoff.
        issue(8'd255, 5'd1, lat);
        in_valid = 1'b1; mant_in = 8'd3; exp_in = 5'd4;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_hold", 32'({mant_out, exp_out, shiftamnt, zero, denorm}),
                32'({8'd255, 5'd1, 4'd0, 1'b0, 1'b0}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_handoff_in_ready",  32'(in_ready),  32'd1);
        chk("bp_handoff_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", 32'(in_ready), 32'd0);
        lat = 0;
        while (lat < 64) begin
            @(posedge clk); lat++; #1;
            if (out_valid) break;
        end
        ref_model(8'd3, 5'd4, rv);
        check_result(rv, lat, "bp_second");
        handoff();

        // Asynchronous reset in the middle of a long shift.
        chk("mid_in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; mant_in = 8'd1; exp_in = 5'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_outputs",   32'({mant_out, exp_out, shiftamnt, zero, denorm}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(8'h05, 5'd12, lat);
        ref_model(8'h05, 5'd12, rv);
        check_result(rv, lat, "post_rst");
        handoff();

        // Randomized operands with random result stalls.
        for (int t = 0; t < 40; t++) begin
            logic [7:0] m;
            logic [4:0] e;
            int stall;
            m = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
            e = 5'($urandom_range(0, 31));
            ref_model(m, e, rv);
            issue(m, e, lat);
            stall = $urandom_range(0, 2);
            repeat (stall) @(posedge clk);
            #1;
            check_result(rv, lat, $sformatf("rnd%0d", t));
            handoff();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
